// File: rtl/execute_if.sv
// Bus between the MIPS execute stage and its neighbours: the ID/EX register contents,
// the MEM/WB writeback bus and the EX/MEM register outputs.
interface execute_if;
  logic        i_con_ex_regdst;
  logic        i_con_ex_alusrc;
  logic [1:0]  i_con_ex_aluop;
  logic        i_con_mem_branch;
  logic        i_con_mem_memread;
  logic        i_con_mem_memwrite;
  logic        i_con_wb_memtoreg;
  logic        i_con_wb_regwrite;
  logic [31:0] i_addr_NextPC;
  logic [31:0] i_data_rs;
  logic [31:0] i_data_rt;
  logic [31:0] i_data_SignExt;
  logic [4:0]  i_addr_rs;
  logic [4:0]  i_addr_mux_0;
  logic [4:0]  i_addr_mux_1;
  logic        i_con_RegWr;
  logic [4:0]  i_addr_WrReg;
  logic [31:0] i_data_WrData;

  logic        o_con_mem_branch;
  logic        o_con_mem_memread;
  logic        o_con_mem_memwrite;
  logic        o_con_wb_memtoreg;
  logic        o_con_wb_regwrite;
  logic [31:0] o_addr_BranchTarget;
  logic        o_con_Zero;
  logic [31:0] o_data_AluResult;
  logic [31:0] o_data_WrMem;
  logic [4:0]  o_addr_WrReg;

  modport slave (
    input  i_con_ex_regdst, i_con_ex_alusrc, i_con_ex_aluop,
    input  i_con_mem_branch, i_con_mem_memread, i_con_mem_memwrite,
    input  i_con_wb_memtoreg, i_con_wb_regwrite,
    input  i_addr_NextPC, i_data_rs, i_data_rt, i_data_SignExt,
    input  i_addr_rs, i_addr_mux_0, i_addr_mux_1,
    input  i_con_RegWr, i_addr_WrReg, i_data_WrData,
    output o_con_mem_branch, o_con_mem_memread, o_con_mem_memwrite,
    output o_con_wb_memtoreg, o_con_wb_regwrite,
    output o_addr_BranchTarget, o_con_Zero, o_data_AluResult,
    output o_data_WrMem, o_addr_WrReg
  );

  modport master (
    output i_con_ex_regdst, i_con_ex_alusrc, i_con_ex_aluop,
    output i_con_mem_branch, i_con_mem_memread, i_con_mem_memwrite,
    output i_con_wb_memtoreg, i_con_wb_regwrite,
    output i_addr_NextPC, i_data_rs, i_data_rt, i_data_SignExt,
    output i_addr_rs, i_addr_mux_0, i_addr_mux_1,
    output i_con_RegWr, i_addr_WrReg, i_data_WrData,
    input  o_con_mem_branch, o_con_mem_memread, o_con_mem_memwrite,
    input  o_con_wb_memtoreg, o_con_wb_regwrite,
    input  o_addr_BranchTarget, o_con_Zero, o_data_AluResult,
    input  o_data_WrMem, o_addr_WrReg
  );
endinterface

// File: rtl/execute.sv
// MIPS execute stage: operand forwarding, ALU, branch target and destination select,
// captured in the EX/MEM register with stall (hold) and flush (bubble).
module execute #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_con_stall,
  input  logic   i_con_flush,
  execute_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_sel_e;

  typedef struct packed {
    logic        mem_branch;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        wb_memtoreg;
    logic        wb_regwrite;
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] wr_mem;
    logic [4:0]  wr_reg;
  } exmem_t;

  function automatic alu_sel_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_sel_e sel;
    sel = ALU_ADD;
    case (aluop)
      2'b01: sel = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100010: sel = ALU_SUB;
          6'b100100: sel = ALU_AND;
          6'b100101: sel = ALU_OR;
          6'b101010: sel = ALU_SLT;
          default:   sel = ALU_ADD;
        endcase
      end
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] alu_calc(input alu_sel_e sel,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic [31:0] y;
    case (sel)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, (a < b)};
      default: y = a + b;
    endcase
    return y;
  endfunction

  // Register 0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic fwd_hit(input logic en, input logic [4:0] wr, input logic [4:0] idx);
    return en && (wr != 5'd0) && (wr == idx);
  endfunction

  exmem_t exmem_q, exmem_d;

  logic               exmem_fwd_en;
  logic signed [31:0] fwd_rs;
  logic signed [31:0] fwd_rt;
  logic signed [31:0] op_b;
  alu_sel_e           alu_sel;
  logic [31:0]        alu_y;

  // Forwarding: a load's EX/MEM value is an address, not data, so it is excluded.
  always_comb begin
    exmem_fwd_en = exmem_q.wb_regwrite & ~exmem_q.mem_memread;
    fwd_rs = bus.i_data_rs;
    fwd_rt = bus.i_data_rt;
    if (FWD_EN) begin
      if (fwd_hit(exmem_fwd_en, exmem_q.wr_reg, bus.i_addr_rs))
        fwd_rs = exmem_q.alu_result;
      else if (fwd_hit(bus.i_con_RegWr, bus.i_addr_WrReg, bus.i_addr_rs))
        fwd_rs = bus.i_data_WrData;
      if (fwd_hit(exmem_fwd_en, exmem_q.wr_reg, bus.i_addr_mux_0))
        fwd_rt = exmem_q.alu_result;
      else if (fwd_hit(bus.i_con_RegWr, bus.i_addr_WrReg, bus.i_addr_mux_0))
        fwd_rt = bus.i_data_WrData;
    end
    op_b    = bus.i_con_ex_alusrc ? bus.i_data_SignExt : fwd_rt;
    alu_sel = alu_decode(bus.i_con_ex_aluop, bus.i_data_SignExt[5:0]);
    alu_y   = alu_calc(alu_sel, fwd_rs, op_b);
  end

  // EX/MEM next state: flush beats stall, stall holds, otherwise load.
  always_comb begin
    exmem_d = exmem_q;
    if (i_con_flush) begin
      exmem_d = '0;
    end else if (!i_con_stall) begin
      exmem_d.mem_branch    = bus.i_con_mem_branch;
      exmem_d.mem_memread   = bus.i_con_mem_memread;
      exmem_d.mem_memwrite  = bus.i_con_mem_memwrite;
      exmem_d.wb_memtoreg   = bus.i_con_wb_memtoreg;
      exmem_d.wb_regwrite   = bus.i_con_wb_regwrite;
      exmem_d.branch_target = bus.i_addr_NextPC + {bus.i_data_SignExt[29:0], 2'b00};
      exmem_d.zero          = (alu_y == 32'h0);
      exmem_d.alu_result    = alu_y;
      exmem_d.wr_mem        = fwd_rt;
      exmem_d.wr_reg        = bus.i_con_ex_regdst ? bus.i_addr_mux_1 : bus.i_addr_mux_0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) exmem_q <= '0;
    else          exmem_q <= exmem_d;
  end

  assign bus.o_con_mem_branch    = exmem_q.mem_branch;
  assign bus.o_con_mem_memread   = exmem_q.mem_memread;
  assign bus.o_con_mem_memwrite  = exmem_q.mem_memwrite;
  assign bus.o_con_wb_memtoreg   = exmem_q.wb_memtoreg;
  assign bus.o_con_wb_regwrite   = exmem_q.wb_regwrite;
  assign bus.o_addr_BranchTarget = exmem_q.branch_target;
  assign bus.o_con_Zero          = exmem_q.zero;
  assign bus.o_data_AluResult    = exmem_q.alu_result;
  assign bus.o_data_WrMem        = exmem_q.wr_mem;
  assign bus.o_addr_WrReg        = exmem_q.wr_reg;

endmodule
